// File: rtl/muladd_pkg.sv
// Shared types and helpers for the muladd reduction stage.
package muladd_pkg;
    localparam int DEF_WIDTH     = 8;
    localparam int DEF_ACC_WIDTH = 16;
    localparam int SAT_W         = 64;

    typedef enum logic [1:0] {SAT_NONE, SAT_POS, SAT_NEG} sat_kind_e;

    typedef struct packed {
        logic                            sat;
        logic [DEF_WIDTH-1:0]            data;
        logic signed [DEF_ACC_WIDTH-1:0] sum;
    } frame_t;

    // Classifies a sign-extended sum against the signed range of a w-bit value.
    function automatic sat_kind_e sat_to_width(input logic signed [SAT_W-1:0] s,
                                               input int unsigned w);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (s > hi)      return SAT_POS;
        else if (s < lo) return SAT_NEG;
        else             return SAT_NONE;
    endfunction
endpackage

// File: rtl/muladd_accum_fifo.sv
// Circular frame FIFO; the head is kept in its own register so outputs are flop-driven.
module muladd_accum_fifo
    import muladd_pkg::*;
#(
    parameter type T     = frame_t,
    parameter int  DEPTH = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic push_i,
    input  T     din_i,
    input  logic ready_i,
    output logic full_o,
    output logic valid_o,
    output T     head_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] PLAST = PW'(DEPTH - 1);
    localparam logic [OW-1:0] OFULL = OW'(DEPTH);

    T              mem_q [DEPTH];
    T              mem_d [DEPTH];
    T              head_q, head_d;
    logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [OW-1:0] occ_q, occ_d;
    logic          valid_q, valid_d;
    logic          pop;

    assign pop     = valid_q && ready_i;
    assign full_o  = (occ_q == OFULL);
    assign valid_o = valid_q;
    assign head_o  = head_q;

    always_comb begin
        mem_d = mem_q;
        rd_d  = rd_q;
        wr_d  = wr_q;
        occ_d = occ_q;
        if (push_i) begin
            mem_d[wr_q] = din_i;
            wr_d = (wr_q == PLAST) ? '0 : wr_q + 1'b1;
        end
        if (pop) rd_d = (rd_q == PLAST) ? '0 : rd_q + 1'b1;
        case ({push_i, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: ;
        endcase
        // Empty FIFO presents an all-zero head, matching the reset state.
        valid_d = (occ_d != '0);
        head_d  = valid_d ? mem_d[rd_d] : '0;
    end

    always_ff @(posedge clock) mem_q <= mem_d;

    always_ff @(posedge clock) begin
        if (!reset) begin
            rd_q    <= '0;
            wr_q    <= '0;
            occ_q   <= '0;
            valid_q <= 1'b0;
            head_q  <= '0;
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            occ_q   <= occ_d;
            valid_q <= valid_d;
            head_q  <= head_d;
        end
    end
endmodule

// File: rtl/muladd_accum.sv
// Sums LEN-sample frames of the muladd result stream and queues raw + saturated frame sums.
module muladd_accum
    import muladd_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int ACC_WIDTH = DEF_ACC_WIDTH,
    parameter int LEN       = 4,
    parameter int DEPTH     = 2
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        in_valid,
    input  logic signed [WIDTH-1:0]     in_data,
    output logic                        in_ready,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [ACC_WIDTH-1:0] out_sum,
    output logic signed [WIDTH-1:0]     out_data,
    output logic                        out_sat
);
    localparam int CW = $clog2(LEN);
    localparam logic [CW-1:0] LAST = CW'(LEN - 1);

    typedef struct packed {
        logic                        sat;
        logic [WIDTH-1:0]            data;
        logic signed [ACC_WIDTH-1:0] sum;
    } frame_l_t;

    logic signed [ACC_WIDTH-1:0] acc_q, acc_d, sum, ext;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic                        accept, push, full;
    sat_kind_e                   kind;
    frame_l_t                    push_frame, head;

    // in_ready looks only at registered state, never at out_ready.
    assign in_ready = (cnt_q != LAST) || !full;
    assign accept   = in_valid && in_ready;
    assign push     = accept && (cnt_q == LAST);
    assign ext      = {{(ACC_WIDTH-WIDTH){in_data[WIDTH-1]}}, in_data};
    assign sum      = acc_q + ext;

    always_comb begin
        kind            = sat_to_width(SAT_W'(sum), WIDTH);
        push_frame.sum  = sum;
        push_frame.sat  = (kind != SAT_NONE);
        case (kind)
            SAT_POS: push_frame.data = {1'b0, {(WIDTH-1){1'b1}}};
            SAT_NEG: push_frame.data = {1'b1, {(WIDTH-1){1'b0}}};
            default: push_frame.data = sum[WIDTH-1:0];
        endcase
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (accept) begin
            if (cnt_q == LAST) begin
                acc_d = '0;
                cnt_d = '0;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    muladd_accum_fifo #(.T(frame_l_t), .DEPTH(DEPTH)) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (push),
        .din_i   (push_frame),
        .ready_i (out_ready),
        .full_o  (full),
        .valid_o (out_valid),
        .head_o  (head)
    );

    assign out_sum  = head.sum;
    assign out_data = head.data;
    assign out_sat  = head.sat;
endmodule

// File: tb/tb_muladd_accum.sv
// Directed + random bench for muladd_accum against a queue-based frame model.
module tb_muladd_accum;
    localparam int W = 8, AW = 16, LEN = 4, DEPTH = 2;

    logic                 clock = 1'b0;
    logic                 reset = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 out_ready = 1'b0;
    logic signed [W-1:0]  in_data = '0;
    logic                 in_ready, out_valid, out_sat;
    logic signed [AW-1:0] out_sum;
    logic signed [W-1:0]  out_data;

    typedef struct {int sum; int data; bit sat;} frm_t;
    frm_t q[$];
    int   msum = 0, mcnt = 0, accepted = 0;
    int   vecs = 0, errs = 0;
    bit   zero_exp = 1'b0;

    always #5 clock = ~clock;

    muladd_accum #(.WIDTH(W), .ACC_WIDTH(AW), .LEN(LEN), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_data(out_data), .out_sat(out_sat)
    );

    function automatic frm_t mk(int s);
        frm_t f;
        f.sum = s;
        f.sat = 1'b1;
        if (s > 127)       f.data = 127;
        else if (s < -128) f.data = -128;
        else begin f.data = s; f.sat = 1'b0; end
        return f;
    endfunction

    task automatic chk(string tag, logic signed [31:0] obs, logic signed [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Check state at the falling edge, then advance the model by what the next rising edge does.
    task automatic cycle();
        bit rdy, acc, pop;
        @(negedge clock);
        rdy = (mcnt != LEN - 1) || (q.size() < DEPTH);
        chk("in_ready", in_ready, rdy);
        chk("out_valid", out_valid, q.size() > 0);
        if (q.size() > 0) begin
            chk("out_sum", out_sum, q[0].sum);
            chk("out_data", out_data, q[0].data);
            chk("out_sat", out_sat, q[0].sat);
        end else if (zero_exp) begin
            chk("rst_sum", out_sum, 0);
            chk("rst_data", out_data, 0);
            chk("rst_sat", out_sat, 0);
        end
        if (!reset) begin
            q.delete();
            msum = 0; mcnt = 0; zero_exp = 1'b1;
        end else begin
            acc = in_valid && rdy;
            pop = (q.size() > 0) && out_ready;
            if (pop) void'(q.pop_front());
            if (acc) begin
                accepted++;
                msum += int'(in_data);
                mcnt++;
                if (mcnt == LEN) begin
                    q.push_back(mk(msum));
                    msum = 0; mcnt = 0; zero_exp = 1'b0;
                end
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic feed(int v, bit rdy);
        in_valid = 1'b1; in_data = 8'(v); out_ready = rdy;
        cycle();
    endtask

    task automatic idle(int n, bit rdy);
        in_valid = 1'b0; out_ready = rdy;
        repeat (n) cycle();
    endtask

    initial begin
        int target;
        int guard;
        // Reset from power-up: first edge with reset low, then check the reset state.
        @(posedge clock);
        #1;
        zero_exp = 1'b1;
        cycle();
        reset = 1'b1;
        cycle();

        // Non-saturating frame
        feed(1, 1); feed(2, 1); feed(3, 1); feed(4, 1);
        idle(3, 1);

        // Positive saturation, held under backpressure for a while
        repeat (4) feed(77, 0);
        idle(3, 0);
        idle(2, 1);

        // Negative saturation
        repeat (4) feed(-100, 1);
        idle(3, 1);

        // Backpressure: fill FIFO, stall, then drain and finish the third frame
        target = accepted + 12;
        in_valid = 1'b1; in_data = 8'sd1; out_ready = 1'b0;
        repeat (15) cycle();
        out_ready = 1'b1;
        guard = 0;
        while (accepted < target && guard < 40) begin
            cycle();
            guard++;
        end
        chk("bp_timeout", guard < 40, 1);
        idle(4, 1);

        // Simultaneous push and pop at occupancy 1
        feed(1, 0); feed(2, 0); feed(3, 0); feed(4, 0);
        feed(5, 0); feed(6, 0); feed(7, 0);
        feed(8, 1);
        idle(1, 0);
        idle(3, 1);

        // Reset mid-frame
        feed(5, 1); feed(5, 1);
        in_valid = 1'b0;
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        cycle();
        repeat (4) feed(1, 1);
        idle(3, 1);

        // Random traffic with occasional resets
        repeat (400) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            reset     = ($urandom_range(0, 149) != 0);
            cycle();
            reset = 1'b1;
        end
        idle(6, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
